md_hilo_unit: RTL and testbench
===============================

MD_HILO_UNIT -- requirements
Module: md_hilo_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port src_a  input  32  multiplicand or dividend.
REQ-007 SHALL have port src_b  input  32  multiplier or divisor.
REQ-008 SHALL have port cancel  input  1  pipeline flush; abort the operation without writeback.
REQ-009 SHALL have port busy  output  1  operation in flight; used as the pipeline stall request.
REQ-010 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port hi_we  output  1  HI write enable towards the HI/LO register file.
REQ-012 SHALL have port lo_we  output  1  LO write enable towards the HI/LO register file.
REQ-013 SHALL have port hi_o  output  32  HI result: product upper half or remainder.
REQ-014 SHALL have port lo_o  output  32  LO result: product lower half or quotient.

Function
REQ-015 SHALL implement states IDLE, MUL, DIV and DONE; IDLE is the only state that accepts start.
REQ-016 SHALL latch op, src_a and src_b on the accepting edge (IDLE, start=1, cancel=0); start is ignored in any other state.
REQ-017 SHALL move IDLE->MUL on MULT/MULTU and IDLE->DIV on DIV/DIVU, with a 6-bit iteration counter cleared to 0.
REQ-018 SHALL perform one shift-add step per cycle in MUL and one restoring-divide step per cycle in DIV; it SHALL go to DONE after the 32nd step.
REQ-019 SHALL define latency as follows: accepting edge = edge 0, 32 step edges, DONE entered on edge 33; done therefore goes high in the cycle after edge 33.
REQ-020 SHALL hold busy=1 in MUL, DIV and DONE, and busy=0 in IDLE.
REQ-021 SHALL drive done=hi_we=lo_we=1 for exactly the one DONE cycle, then return to IDLE.
REQ-022 SHALL hold hi_o/lo_o at the last result from DONE until the next DONE.
REQ-023 SHALL compute signed ops on operand magnitudes with a final sign fix.
REQ-024 SHALL negate the product when the operand signs differ.
REQ-025 SHALL make the quotient negative when the operand signs differ, and give the remainder the sign of the dividend.
REQ-026 SHALL treat operand 0x80000000 as magnitude 2^31 without overflow.
REQ-027 SHALL, for DIV/DIVU with src_b=0, skip the iterations: IDLE->DIV->DONE, done goes high in the cycle after edge 2, hi_o=src_a, lo_o=0xFFFFFFFF.
REQ-028 SHALL, when cancel=1 in MUL or DIV, return to IDLE on the next edge with no DONE cycle.
REQ-029 SHALL force done/hi_we/lo_we to 0 when cancel=1 in DONE, combinationally in that cycle.
REQ-030 SHALL give cancel priority over start when both are 1 in IDLE: no operation is accepted.

Reset
REQ-031 SHALL, on rst=0, immediately force state IDLE, counter 0, busy=0, done=0, hi_we=0, lo_we=0, hi_o=0, lo_o=0 and internal datapath registers 0.
REQ-032 SHALL, on reset mid-operation, discard the operation with no write pulse, and keep the block idle until the first edge with rst=1.

Configuration
REQ-033 SHALL, when macro MD_FAST_MUL_EN is defined, compute MULT/MULTU with a single-cycle multiplier: IDLE->DONE on edge 1, done goes high in the cycle after edge 1, MUL state unused.
REQ-034 SHALL, when MD_FAST_MUL_EN is undefined, use the 32-step iterative multiplier per REQ-018/019; divide behaviour is identical in both builds.

Structure
REQ-035 SHALL place the op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and the state encodings in shared package md_pkg.
REQ-036 SHALL place the restoring-divide datapath in sub-module md_div_core (operand/counter inputs, quotient/remainder outputs); the FSM and multiplier stay in md_hilo_unit.

Verification
REQ-037 SHALL cover MULT src_a=0xFFFFFFFD, src_b=5 -> done in the cycle after edge 33 (iterative build), hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1, hi_we=lo_we=1 for one cycle.
REQ-038 SHALL cover MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001; and in the MD_FAST_MUL_EN build, done in the cycle after edge 1.
REQ-039 SHALL cover DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIVU 100/7 -> lo_o=0x0000000E, hi_o=0x00000002; and a start held high while busy -> ignored.
REQ-040 SHALL cover DIV 0x12345678/0 -> done in the cycle after edge 2, hi_o=0x12345678, lo_o=0xFFFFFFFF.
REQ-041 SHALL cover cancel at step 10 of DIVU -> IDLE next edge, no done/hi_we/lo_we, previous hi_o/lo_o held; and cancel with start in IDLE -> busy stays 0.
REQ-042 SHALL cover rst=0 at step 20 of MULT -> all outputs 0 immediately; a new start after rst=1 completes correctly.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide unit.
// Operation codes, FSM state encodings and operand magnitude helper.
package md_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_STEPS = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // 0x80000000 negates to itself, which read unsigned is exactly 2^31.
    function automatic logic [MD_WIDTH-1:0] magnitude(input logic [MD_WIDTH-1:0] v,
                                                       input logic sgn);
        return (sgn && v[MD_WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/md_div_core.sv
// Restoring-divide datapath: one quotient bit per step on unsigned magnitudes.
// Steps run while cnt < 32; quotient/remainder are valid after the 32nd step.
module md_div_core
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step_en,
    input  logic [5:0]       cnt,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             do_step;

    assign do_step = step_en && (cnt < 6'(MD_STEPS));
    assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
    // A set top bit means the trial subtraction went negative: restore.
    assign diff    = rem_sh - {1'b0, divisor};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q <= '0;
            quo_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
        end else if (do_step) begin
            if (!diff[WIDTH]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/md_hilo_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit writing HI/LO; busy doubles as stall.
// Define MD_FAST_MUL_EN for a single-cycle multiplier (divide is unchanged).
//
// state   | meaning
// IDLE    | waiting for start; only state that accepts an operation
// MUL     | shift-add multiply steps (one cycle only in fast-multiply build)
// DIV     | restoring divide steps; zero divisor skips straight to finish
// DONE    | one-cycle result pulse on done/hi_we/lo_we
module md_hilo_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    md_state_e          state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    md_op_e             op_q;
    logic [WIDTH-1:0]   a_raw_q, a_mag_q, b_mag_q;
    logic               neg_res_q, neg_rem_q;
    logic [2*WIDTH-1:0] prod_q;

    md_op_e             op_in;
    logic               in_signed;
    logic [WIDTH-1:0]   a_mag_d, b_mag_d;
    logic               accept, b_zero, mul_last, div_last, enter_done;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_mag, mul_res;
    logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;

    assign op_in     = md_op_e'(op);
    assign in_signed = op_is_signed(op_in);
    assign a_mag_d   = magnitude(src_a, in_signed);
    assign b_mag_d   = magnitude(src_b, in_signed);
    assign accept    = (state_q == ST_IDLE) && start && !cancel;
    assign b_zero    = (b_mag_q == '0);
    assign div_last  = (cnt_q == 6'(MD_STEPS));
`ifdef MD_FAST_MUL_EN
    assign mul_last  = 1'b1;
    assign mul_mag   = (2*WIDTH)'(a_mag_q) * (2*WIDTH)'(b_mag_q);
`else
    assign mul_last  = (cnt_q == 6'(MD_STEPS));
    assign mul_mag   = prod_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = op_is_div(op_in) ? ST_DIV : ST_MUL;
                    cnt_d   = '0;
                end
            end
            ST_MUL: begin
                if (cancel)        state_d = ST_IDLE;
                else if (mul_last) state_d = ST_DONE;
                else               cnt_d   = cnt_q + 6'd1;
            end
            ST_DIV: begin
                if (cancel)        state_d = ST_IDLE;
                else if (div_last) state_d = ST_DONE;
                else if (b_zero)   cnt_d   = 6'(MD_STEPS);
                else               cnt_d   = cnt_q + 6'd1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE) && !cancel;
    assign hi_we      = done;
    assign lo_we      = done;

    // Shift-add: conditionally add the multiplicand into the upper half, shift right.
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};
    assign mul_res  = neg_res_q ? (~mul_mag + 1'b1) : mul_mag;
    assign quo_fix  = neg_res_q ? (~quo + 1'b1) : quo;
    assign rem_fix  = neg_rem_q ? (~rem + 1'b1) : rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= MD_MULT;
            a_raw_q   <= '0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            prod_q    <= '0;
            hi_o      <= '0;
            lo_o      <= '0;
        end else begin
            if (accept) begin
                op_q      <= op_in;
                a_raw_q   <= src_a;
                a_mag_q   <= a_mag_d;
                b_mag_q   <= b_mag_d;
                neg_res_q <= in_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                neg_rem_q <= in_signed && src_a[WIDTH-1];
                prod_q    <= {{WIDTH{1'b0}}, b_mag_d};
            end else if ((state_q == ST_MUL) && !cancel && !mul_last) begin
                prod_q <= mul_next;
            end
            if (enter_done) begin
                if (!op_is_div(op_q)) begin
                    hi_o <= mul_res[2*WIDTH-1:WIDTH];
                    lo_o <= mul_res[WIDTH-1:0];
                end else if (b_zero) begin
                    hi_o <= a_raw_q;
                    lo_o <= '1;
                end else begin
                    hi_o <= rem_fix;
                    lo_o <= quo_fix;
                end
            end
        end
    end

    md_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step_en  ((state_q == ST_DIV) && !cancel && !b_zero),
        .cnt      (cnt_q),
        .dividend (a_mag_d),
        .divisor  (b_mag_q),
        .quotient (quo),
        .remainder(rem)
    );

endmodule

// File: tb/tb_md_hilo_unit.sv
// Directed vector bench for md_hilo_unit: result table plus cancel/reset sequences.
module tb_md_hilo_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy, done, hi_we, lo_we;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    md_hilo_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .cancel(cancel),
        .busy  (busy),
        .done  (done),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .hi_o  (hi_o),
        .lo_o  (lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
        if (o[1]) return (b == 32'd0) ? 2 : 33;
`ifdef MD_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    // Returns the number of edges after the accepting edge until done is seen (-1 on timeout).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic hold_start, output int lat);
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        else begin
            src_a = a ^ 32'h5A5A_5A5A;
            src_b = b + 32'd1;
        end
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [1:0] o, input logic [31:0] b,
                                input logic [31:0] ehi, input logic [31:0] elo, input int lat);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat(o, b)));
        chk({tag, " hi_o"}, hi_o, ehi);
        chk({tag, " lo_o"}, lo_o, elo);
        chk({tag, " hi_we"}, {31'd0, hi_we}, 32'd1);
        chk({tag, " lo_we"}, {31'd0, lo_we}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " done drop"}, {31'd0, done}, 32'd0);
        chk({tag, " busy drop"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        logic seen;

        vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{2'b11, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E};
        vecs[4]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[5]  = '{2'b00, 32'h8000_0000, 32'd1,        32'hFFFF_FFFF, 32'h8000_0000};
        vecs[6]  = '{2'b10, 32'h8000_0000, 32'd2,        32'h0000_0000, 32'hC000_0000};
        vecs[7]  = '{2'b11, 32'h8000_0000, 32'd3,        32'h0000_0002, 32'h2AAA_AAAA};
        vecs[8]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{2'b01, 32'h1234_5678, 32'h10,       32'h0000_0001, 32'h2345_6780};
        vecs[10] = '{2'b10, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF};
        vecs[11] = '{2'b11, 32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFF};

        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset we", {30'd0, hi_we, lo_we}, 32'd0);
        chk("reset hi_o", hi_o, 32'd0);
        chk("reset lo_o", lo_o, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat);
            check_result($sformatf("vec%0d", i), vecs[i].op, vecs[i].b, vecs[i].hi, vecs[i].lo, lat);
        end

        // start held high through the operation while operands change: ignored.
        run_op(2'b11, 32'd100, 32'd7, 1'b1, lat);
        check_result("hold_start", 2'b11, 32'd7, 32'h2, 32'hE, lat);

        // Cancel DIVU after its 10th step: no pulse, previous result held.
        @(negedge clk);
        op = 2'b11; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_div busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || hi_we || lo_we) seen = 1'b1;
        end
        chk("cancel_div no pulse", {31'd0, seen}, 32'd0);
        chk("cancel_div hi held", hi_o, 32'h2);
        chk("cancel_div lo held", lo_o, 32'hE);

        // Cancel during the DONE cycle masks the write pulse combinationally.
        run_op(2'b01, 32'd3, 32'd4, 1'b0, lat);
        chk("cancel_done latency", 32'(lat), 32'(exp_lat(2'b01, 32'd4)));
        cancel = 1'b1;
        #1;
        chk("cancel_done done", {31'd0, done}, 32'd0);
        chk("cancel_done we", {30'd0, hi_we, lo_we}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_done busy", {31'd0, busy}, 32'd0);

        // cancel beats start in IDLE.
        @(negedge clk);
        op = 2'b00; src_a = 32'd2; src_b = 32'd3; start = 1'b1; cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("cancel_start busy", {31'd0, busy}, 32'd0);
        start = 1'b0; cancel = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("cancel_start no op", {31'd0, seen}, 32'd0);

        // Reset at step 20 of MULT clears everything at once.
        @(negedge clk);
        op = 2'b00; src_a = 32'hFFFF_FFFD; src_b = 32'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid busy", {31'd0, busy}, 32'd0);
        chk("rst_mid done", {31'd0, done}, 32'd0);
        chk("rst_mid we", {30'd0, hi_we, lo_we}, 32'd0);
        chk("rst_mid hi_o", hi_o, 32'd0);
        chk("rst_mid lo_o", lo_o, 32'd0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hold busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        rst = 1'b1;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, lat);
        check_result("post_rst", 2'b00, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, lat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
